// File: rtl/traffic_phase_ctrl.sv
// Two-road traffic phase controller: programmable green/yellow/all-red timing, pedestrian
// green-shortening with acknowledge, and night flashing-yellow mode; per-road binary countdowns.
module traffic_phase_ctrl #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int GREEN_TIME  = 27,
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 2,
    parameter int PED_REMAIN  = 5,
    parameter int CNT_W       = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             night_en,
    input  logic             ped_req,
    output logic             ped_ack,
    output logic [5:0]       led,
    output logic [CNT_W-1:0] ew_cnt,
    output logic [CNT_W-1:0] ns_cnt,
    output logic             sec_tick
);

    localparam int DIV_W = $clog2(CLK_FREQ);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_FREQ - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_FREQ / 2 - 1);
    localparam logic [CNT_W-1:0] G_C      = CNT_W'(GREEN_TIME);
    localparam logic [CNT_W-1:0] Y_C      = CNT_W'(YELLOW_TIME);
    localparam logic [CNT_W-1:0] A_C      = CNT_W'(ALLRED_TIME);
    localparam logic [CNT_W-1:0] PED_C    = CNT_W'(PED_REMAIN);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAP_C    = G_C + Y_C + A_C;

    typedef enum logic [2:0] {
        S_EW_G, S_EW_Y, S_AR1, S_NS_G, S_NS_Y, S_AR2, S_FLASH
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_rem;
    logic             r_ped_pend;
    logic             r_ped_hold;
    logic             r_ped_ack;
    logic             r_y;

    logic w_tick;
    logic w_half_tick;
    logic w_expire;

    assign w_tick      = (r_div == DIV_LAST);
    assign w_half_tick = w_tick || (r_div == DIV_HALF);
    assign w_expire    = w_tick && (r_rem == ONE_C);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_div      <= '0;
            r_state    <= S_EW_G;
            r_rem      <= G_C;
            r_ped_pend <= 1'b0;
            r_ped_hold <= 1'b0;
            r_ped_ack  <= 1'b0;
            r_y        <= 1'b1;
        end else begin
            r_div     <= w_tick ? '0 : r_div + DIV_W'(1);
            r_ped_ack <= 1'b0;
            case (r_state)
                S_EW_G, S_NS_G: begin
                    if (ped_req) r_ped_pend <= 1'b1;
                    if (w_expire) begin
                        r_state <= (r_state == S_EW_G) ? S_EW_Y : S_NS_Y;
                        r_rem   <= Y_C;
                    end else if (r_ped_pend && (r_rem > PED_C)) begin
                        r_rem <= PED_C;
                    end else if (w_tick) begin
                        r_rem <= r_rem - ONE_C;
                    end
                end
                // Requests seen in yellow are parked so they survive the all-red retirement.
                S_EW_Y, S_NS_Y: begin
                    if (ped_req) r_ped_hold <= 1'b1;
                    if (w_expire) begin
                        r_state    <= (r_state == S_EW_Y) ? S_AR1 : S_AR2;
                        r_rem      <= A_C;
                        r_ped_ack  <= r_ped_pend;
                        r_ped_pend <= r_ped_hold | ped_req;
                        r_ped_hold <= 1'b0;
                    end else if (w_tick) begin
                        r_rem <= r_rem - ONE_C;
                    end
                end
                S_AR1, S_AR2: begin
                    if (ped_req) r_ped_pend <= 1'b1;
                    if (w_expire) begin
                        if (night_en) begin
                            r_state    <= S_FLASH;
                            r_ped_pend <= 1'b0;
                            r_ped_hold <= 1'b0;
                            r_y        <= 1'b1;
                        end else begin
                            r_state <= (r_state == S_AR1) ? S_NS_G : S_EW_G;
                            r_rem   <= G_C;
                        end
                    end else if (w_tick) begin
                        r_rem <= r_rem - ONE_C;
                    end
                end
                S_FLASH: begin
                    if (w_half_tick) r_y <= ~r_y;
                    if (w_tick && !night_en) begin
                        r_state <= S_AR1;
                        r_rem   <= A_C;
                    end
                end
                default: r_state <= S_EW_G;
            endcase
        end
    end

    // Red roads count through every intervening phase up to their own green.
    always_comb begin
        led    = 6'b000000;
        ew_cnt = '0;
        ns_cnt = '0;
        case (r_state)
            S_EW_G: begin
                led    = 6'b001100;
                ew_cnt = r_rem + Y_C;
                ns_cnt = r_rem + Y_C + A_C;
            end
            S_EW_Y: begin
                led    = 6'b010100;
                ew_cnt = r_rem;
                ns_cnt = r_rem + A_C;
            end
            S_AR1: begin
                led    = 6'b100100;
                ew_cnt = r_rem + LAP_C;
                ns_cnt = r_rem;
            end
            S_NS_G: begin
                led    = 6'b100001;
                ew_cnt = r_rem + Y_C + A_C;
                ns_cnt = r_rem + Y_C;
            end
            S_NS_Y: begin
                led    = 6'b100010;
                ew_cnt = r_rem + A_C;
                ns_cnt = r_rem;
            end
            S_AR2: begin
                led    = 6'b100100;
                ew_cnt = r_rem;
                ns_cnt = r_rem + LAP_C;
            end
            S_FLASH: led = r_y ? 6'b010010 : 6'b000000;
            default: led = 6'b000000;
        endcase
    end

    assign ped_ack  = r_ped_ack;
    assign sec_tick = w_tick;

endmodule
